controlador_interrupcao: RTL

- Parametrised successor to the single-timer/halt interrupt unit, sitting between the datapath and the control unit.
- Merges three source types into one prioritised request with a cause code and a saved return PC, handshaked with the control unit:
  - halt;
  - a quantum timer, one-shot or periodic;
  - N_EXT external IRQ lines.
- The OS programs the timer and the enable mask. The control unit acknowledges entry and signals end-of-interrupt.

---
 rtl/interrupcao_pkg.sv | 24 ++
 rtl/timer_quantum.sv | 50 +++++
 rtl/controlador_interrupcao.sv | 117 +++++++++++
 3 files changed

// File: rtl/interrupcao_pkg.sv
// Shared constants for the interrupt controller: source indices, FSM encoding
// and the cause-code width helper.
package interrupcao_pkg;

  localparam int CAUSE_HALT     = 0;
  localparam int CAUSE_TIMER    = 1;
  localparam int CAUSE_EXT_BASE = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    SERVICE = ST_SERVICE
  } state_t;

  // A single source still needs a one-bit cause field.
  function automatic int f_cause_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/timer_quantum.sv
// Quantum timer: counts from 0 up to the loaded reload value, then expires
// and either stops (one-shot) or restarts from 0 (periodic).
module timer_quantum #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set,
  input  logic                   periodic,
  input  logic [TIMER_WIDTH-1:0] int_time,
  input  logic                   stop,
  output logic                   expire,
  output logic                   busy
);

  logic [TIMER_WIDTH-1:0] r_counter;
  logic [TIMER_WIDTH-1:0] r_reload;
  logic                   r_running;
  logic                   r_mode;
  logic                   w_at_limit;

  assign w_at_limit = (r_counter >= r_reload);
  // stop and set both pre-empt the count, so neither edge can also expire
  assign expire     = r_running & ~set & ~stop & ~rst & w_at_limit;
  assign busy       = r_running;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_counter <= '0;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_mode    <= 1'b0;
    end else if (stop) begin
      r_running <= 1'b0;
    end else if (set) begin
      r_counter <= '0;
      r_running <= 1'b1;
      r_reload  <= int_time;
      r_mode    <= periodic;
    end else if (r_running) begin
      if (w_at_limit) begin
        r_counter <= '0;
        r_running <= r_mode;
      end else begin
        r_counter <= r_counter + TIMER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/controlador_interrupcao.sv
// Interrupt controller: merges halt, quantum timer and external IRQs into one
// prioritised request with cause and saved PC, handshaked via ack/eoi.
module controlador_interrupcao
  import interrupcao_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 13,
  parameter  int TIMER_WIDTH = 16,
  parameter  int N_EXT       = 4,
  localparam int N_SRC       = N_EXT + 2,
  localparam int CAUSE_W     = f_cause_w(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   set,
  input  logic                   periodic,
  input  logic [TIMER_WIDTH-1:0] int_time,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [N_EXT-1:0]       ext_irq,
  input  logic                   mask_we,
  input  logic [N_SRC-1:0]       mask_in,
  input  logic                   ack,
  input  logic                   eoi,
  output logic                   int_req,
  output logic [CAUSE_W-1:0]     int_cause,
  output logic [ADDR_WIDTH-1:0]  epc,
  output logic                   int_halt,
  output logic                   int_clk,
  output logic                   timer_busy
);

  state_t                r_state, w_state_nxt;
  logic [N_SRC-1:0]      r_pending, r_mask;
  logic [N_SRC-1:0]      w_event, w_clr, w_cand;
  logic [N_EXT-1:0]      r_ext_prev, w_ext_rise;
  logic [CAUSE_W-1:0]    r_cause, w_sel;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic                  r_int_halt, r_int_clk;
  logic                  w_tmr_expire, w_latch;

  timer_quantum #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .periodic (periodic),
    .int_time (int_time),
    .stop     (halt),
    .expire   (w_tmr_expire),
    .busy     (timer_busy)
  );

  for (genvar i = 0; i < N_EXT; i++) begin : g_ext_edge
    assign w_ext_rise[i] = ext_irq[i] & ~r_ext_prev[i];
  end

  always_comb begin
    w_event                          = '0;
    w_event[CAUSE_HALT]              = halt;
    w_event[CAUSE_TIMER]             = w_tmr_expire;
    w_event[CAUSE_EXT_BASE +: N_EXT] = w_ext_rise;
  end

  assign w_cand = r_pending & r_mask;
  assign w_clr  = (r_state == REQ && ack) ? (N_SRC'(1) << r_cause) : '0;

  // Scan from the top so the lowest set index wins.
  always_comb begin
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel = CAUSE_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (|w_cand) w_state_nxt = REQ;
      REQ:     if (ack)     w_state_nxt = SERVICE;
      SERVICE: if (eoi)     w_state_nxt = IDLE;
      default:              w_state_nxt = IDLE;
    endcase
  end

  assign w_latch = (r_state == IDLE) && (|w_cand);

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_mask     <= '1;
      r_ext_prev <= '0;
      r_cause    <= '0;
      r_epc      <= '0;
      r_int_halt <= 1'b0;
      r_int_clk  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // A new event on the bit being acknowledged keeps it pending.
      r_pending  <= (r_pending & ~w_clr) | w_event;
      r_ext_prev <= ext_irq;
      r_int_halt <= w_event[CAUSE_HALT];
      r_int_clk  <= w_event[CAUSE_TIMER];
      if (mask_we) r_mask <= mask_in | N_SRC'(1);
      if (w_latch) begin
        r_cause <= w_sel;
        r_epc   <= pc;
      end
    end
  end

  assign int_req   = (r_state == REQ);
  assign int_cause = r_cause;
  assign epc       = r_epc;
  assign int_halt  = r_int_halt;
  assign int_clk   = r_int_clk;

endmodule
